// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ULA.
// Imported by ula_seq and ula_mul_iter.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative unsigned shift-add multiplier; bit 0 of b is consumed at start, one more bit per busy cycle.
// done/product are valid WIDTH-1 cycles after start; no backpressure, the caller samples product on done.
module ula_mul_iter import ula_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] step_acc;

  always_comb begin
    step_acc = acc + (mplier[0] ? mcand : '0);
  end

  // The final partial product is folded in combinationally so the result is ready on done.
  assign product = step_acc;
  assign done    = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Registered ULA with flags: latency 1 for all ops, WIDTH for MUL when ULA_MUL_EN is defined (else op 111 = PASS B).
// Input valid/ready (in_ready low only while multiplying); no output backpressure, out_valid is a 1-cycle pulse.
module ula_seq import ula_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       sel_ULA,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

  logic             accept;
  logic [WIDTH-1:0] res;
  flags_t           fl;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] out_q;
  flags_t           flags_q;
  logic             out_valid_q;

  assign accept = in_valid && in_ready;

  always_comb begin
    res = '0;
    fl  = '0;
    sum = '0;
    shl = '0;
    case (sel_ULA)
      OP_ADD: begin
        sum  = {1'b0, op_a} + {1'b0, op_b};
        res  = sum[MSB:0];
        fl.c = sum[WIDTH];
        fl.v = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        sum  = {1'b0, op_a} - {1'b0, op_b};
        res  = sum[MSB:0];
        fl.c = sum[WIDTH];
        fl.v = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_NOT: res = ~op_a;
      OP_SHL: begin
        if ({1'b0, op_b} < WIDTH_EXT) begin
          shl  = {1'b0, op_a} << op_b;
          res  = shl[MSB:0];
          fl.c = shl[WIDTH];
        end
      end
      default: begin
`ifdef ULA_MUL_EN
        res = '0;
`else
        res = op_b;
`endif
      end
    endcase
    fl.z = (res == '0);
    fl.n = res[MSB];
  end

`ifdef ULA_MUL_EN
  state_t             state;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mul_res;
  flags_t             mul_fl;

  assign in_ready  = (state == ST_IDLE);
  assign mul_start = accept && (sel_ULA == OP_MUL);

  ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .done    (mul_done),
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  always_comb begin
    mul_res  = product[MSB:0];
    mul_fl   = '0;
    mul_fl.z = (mul_res == '0);
    mul_fl.n = mul_res[MSB];
    mul_fl.c = |product[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (state == ST_BUSY) begin
        if (mul_done) begin
          out_q       <= mul_res;
          flags_q     <= mul_fl;
          out_valid_q <= 1'b1;
          state       <= ST_IDLE;
        end
      end else if (accept) begin
        if (sel_ULA == OP_MUL) begin
          state <= ST_BUSY;
        end else begin
          out_q       <= res;
          flags_q     <= fl;
          out_valid_q <= 1'b1;
        end
      end
    end
  end
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_q   <= res;
        flags_q <= fl;
      end
    end
  end
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=4; flags compared as {z,n,c,v}.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [2:0] sel_ULA;
  logic       out_valid;
  logic [3:0] out;
  logic       flag_z, flag_n, flag_c, flag_v;

  int vectors = 0;
  int fails   = 0;

  ula_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sel_ULA   (sel_ULA),
    .out_valid (out_valid),
    .out       (out),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    sel_ULA  = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic result(input string tag, input logic [3:0] exp_out, input logic [3:0] exp_fl);
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".flg"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_fl));
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp_out, input logic [3:0] exp_fl);
    drive(op, a, b);
    step();
    in_valid = 1'b0;
    result(tag, exp_out, exp_fl);
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sel_ULA = '0;
    step();
    step();
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.out", 32'(out), 32'd0);
    check("rst.flg", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("rst.rdy", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    check("idle.vld", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle ops: valid stays high across these calls.
    single("add_c_3",  3'b000, 4'b1100, 4'b0011, 4'b1111, 4'b0100);
    single("sub_b_f",  3'b001, 4'b1011, 4'b1111, 4'b1100, 4'b0110);
    single("add_ovf",  3'b000, 4'b0111, 4'b0001, 4'b1000, 4'b0101);
    single("add_carry",3'b000, 4'b1000, 4'b1000, 4'b0000, 4'b1011);
    single("sub_ovf",  3'b001, 4'b1000, 4'b0001, 4'b0111, 4'b0001);
    single("and",      3'b010, 4'b1100, 4'b1010, 4'b1000, 4'b0100);
    single("or_zero",  3'b011, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    single("xor",      3'b100, 4'b0101, 4'b0110, 4'b0011, 4'b0000);
    single("not",      3'b101, 4'b0101, 4'b1111, 4'b1010, 4'b0100);
    single("shl_9_2",  3'b110, 4'b1001, 4'b0010, 4'b0100, 4'b0000);
    single("shl_a_1",  3'b110, 4'b1010, 4'b0001, 4'b0100, 4'b0010);
    single("shl_f_3",  3'b110, 4'b1111, 4'b0011, 4'b1000, 4'b0110);
    single("shl_f_4",  3'b110, 4'b1111, 4'b0100, 4'b0000, 4'b1000);
    single("shl_f_9",  3'b110, 4'b1111, 4'b1001, 4'b0000, 4'b1000);
    single("shl_9_0",  3'b110, 4'b1001, 4'b0000, 4'b1001, 4'b0100);

    // No acceptance: pulse drops, result and flags hold.
    op_a = 4'b0001; op_b = 4'b0001; sel_ULA = 3'b000;
    step();
    check("hold.vld", 32'(out_valid), 32'd0);
    check("hold.out", 32'(out), 32'h9);
    check("hold.flg", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h4);

`ifdef ULA_MUL_EN
    drive(3'b111, 4'b1010, 4'b0011);
    step();
    // Offer an ADD during the busy cycles; it must be ignored.
    drive(3'b000, 4'b1111, 4'b1111);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("mul.busy%0d.rdy", i), 32'(in_ready), 32'd0);
      check($sformatf("mul.busy%0d.vld", i), 32'(out_valid), 32'd0);
      if (i == 3) drive(3'b000, 4'b0001, 4'b0010);
      step();
    end
    result("mul_a_3", 4'b1110, 4'b0110);
    check("mul.done.rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    result("add_after_mul", 4'b0011, 4'b0000);

    drive(3'b111, 4'b0011, 4'b0101);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    result("mul_3_5", 4'b1111, 4'b0100);

    // Abort: reset lands 2 cycles into the multiply while an ADD is offered.
    drive(3'b111, 4'b1111, 4'b1111);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    drive(3'b000, 4'b0001, 4'b0001);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("abort.vld", 32'(out_valid), 32'd0);
    check("abort.out", 32'(out), 32'd0);
    check("abort.flg", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("abort.rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort.quiet%0d", i), 32'(out_valid), 32'd0);
    end
    single("add_post_abort", 3'b000, 4'b0010, 4'b0011, 4'b0101, 4'b0000);
`else
    single("passb", 3'b111, 4'b1010, 4'b0110, 4'b0110, 4'b0000);
    single("passb_z", 3'b111, 4'b1111, 4'b0000, 4'b0000, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("passb.rdy%0d", i), 32'(in_ready), 32'd1);
    end
    // Reset wins over a simultaneous valid op.
    rst = 1'b1;
    drive(3'b000, 4'b0001, 4'b0001);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rstpri.vld", 32'(out_valid), 32'd0);
    check("rstpri.out", 32'(out), 32'd0);
    check("rstpri.rdy", 32'(in_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
